// File: rtl/axis_ready_pipeline_pkg.sv
// Shared constants and helpers for the ready-pipelined AXI-Stream register chain.
package axis_pipe_pkg;

    // Smallest receive FIFO that can absorb every beat in flight once ready falls.
    function automatic int unsigned min_fifo_depth(int unsigned length);
        return 2 * length + 2;
    endfunction

    function automatic int unsigned clog2(int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/axis_ready_pipeline_if.sv
// AXI-Stream bundle used for both the sink-facing and source-facing sides of the pipeline.
interface axis_ready_pipeline_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned KEEP_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_ready_pipeline_fifo.sv
// Synchronous receive FIFO with non-power-of-two wrap and post-update occupancy output.
// AXIS_READY_PIPE_OVF_CHECK_EN adds a sticky overflow/underflow flag and drops overflowing pushes.
module axis_ready_pipeline_fifo
    import axis_pipe_pkg::*;
#(
    parameter  int unsigned Width = 8,
    parameter  int unsigned Depth = 6,
    localparam int unsigned CntW  = clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_next_o,
    output logic             ovf_o
);
    localparam int unsigned PtrW = clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             wr_en, rd_en;

`ifdef AXIS_READY_PIPE_OVF_CHECK_EN
    logic ovf_q;
    assign wr_en = push_i && (count_q != CntW'(Depth));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((push_i && count_q == CntW'(Depth)) || (pop_i && count_q == '0)) begin
            ovf_q <= 1'b1;
        end
    end
    assign ovf_o = ovf_q;
`else
    assign wr_en = push_i;
    assign ovf_o = 1'b0;
`endif

    assign rd_en        = pop_i && (count_q != '0);
    assign empty_o      = (count_q == '0);
    assign rdata_o      = mem_q[rptr_q];
    assign count_next_o = count_d;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && rd_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (rd_en) begin
                rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/axis_ready_pipeline.sv
// AXI-Stream register chain that pipelines both data (forward) and tready (backward).
// AXIS_READY_PIPE_OVF_CHECK_EN enables the sticky status_overflow check in the receive FIFO.
module axis_ready_pipeline
    import axis_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter bit          LAST_ENABLE = 1'b1,
    parameter bit          USER_ENABLE = 1'b1,
    parameter int unsigned USER_WIDTH  = 1,
    parameter int unsigned LENGTH      = 2,
    parameter int unsigned FIFO_DEPTH  = min_fifo_depth(LENGTH)
) (
    input  logic clk,
    input  logic rst,
    axis_ready_pipeline_if.slave  s_axis,
    axis_ready_pipeline_if.master m_axis,
    output logic status_overflow
);
    localparam int unsigned PW     = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
    localparam int unsigned CntW   = clog2(FIFO_DEPTH + 1);
    localparam int unsigned Thresh = FIFO_DEPTH - 2 * LENGTH - 1;

    if (LENGTH < 1 || FIFO_DEPTH < min_fifo_depth(LENGTH)) begin : g_param_err
        $error("axis_ready_pipeline: LENGTH must be >=1 and FIFO_DEPTH >= 2*LENGTH+2");
    end

    logic [PW-1:0]     s_pay;
    logic [PW-1:0]     fifo_rdata;
    logic              s_fire, fifo_empty, rdy_src_q;
    logic [LENGTH-1:0] fwd_vld_q, bwd_q;
    logic [PW-1:0]     fwd_pay_q [LENGTH];
    logic [CntW-1:0]   count_next;

    // Disabled sideband fields are replaced by their constant values before storage.
    assign s_pay = {s_axis.tdata,
                    KEEP_ENABLE ? s_axis.tkeep : {KEEP_WIDTH{1'b1}},
                    LAST_ENABLE ? s_axis.tlast : 1'b1,
                    USER_ENABLE ? s_axis.tuser : {USER_WIDTH{1'b0}}};

    assign s_fire        = s_axis.tvalid && s_axis.tready;
    assign s_axis.tready = bwd_q[LENGTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_vld_q <= '0;
            bwd_q     <= '0;
            rdy_src_q <= 1'b0;
        end else begin
            rdy_src_q    <= (count_next <= CntW'(Thresh));
            fwd_vld_q[0] <= s_fire;
            bwd_q[0]     <= rdy_src_q;
            for (int unsigned i = 1; i < LENGTH; i++) begin
                fwd_vld_q[i] <= fwd_vld_q[i-1];
                bwd_q[i]     <= bwd_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        fwd_pay_q[0] <= s_pay;
        for (int unsigned i = 1; i < LENGTH; i++) begin
            fwd_pay_q[i] <= fwd_pay_q[i-1];
        end
    end

    axis_ready_pipeline_fifo #(
        .Width (PW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (fwd_vld_q[LENGTH-1]),
        .wdata_i      (fwd_pay_q[LENGTH-1]),
        .pop_i        (m_axis.tvalid && m_axis.tready),
        .rdata_o      (fifo_rdata),
        .empty_o      (fifo_empty),
        .count_next_o (count_next),
        .ovf_o        (status_overflow)
    );

    assign m_axis.tvalid = !fifo_empty;
    assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser} = fifo_rdata;

endmodule

// File: tb/tb_axis_ready_pipeline.sv
// Bench for axis_ready_pipeline: two configurations, each checked every cycle against a
// transaction-level model (in-flight delay queue, FIFO queue, delayed-ready history).
module tb_axis_ready_pipeline;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int src_mode [2];  // 0 idle, 1 always valid up to lim, 2 random
    int snk_mode [2];  // 0 stalled, 1 always ready, 2 random
    int lim      [2];
    bit chk_en   [2];

    typedef struct {
        logic [19:0] b;
        int          arr;
    } fl_t;

    task automatic chk(input string nm, input int gi, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] t=%0t got %0h expected %0h", nm, gi, $time, act, exp);
        end
    endtask

    function automatic logic [19:0] mk(int n);
        logic [15:0] d;
        d = 16'(n * 37 + 5);
        return {d, 2'(n), (n % 4 == 3), 1'(n >> 1)};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int L  = (gi == 0) ? 2 : 3;
        localparam int D  = (gi == 0) ? 6 : 8;
        localparam bit KE = (gi == 0);
        localparam bit LE = (gi == 0);

        axis_ready_pipeline_if #(.DATA_WIDTH(16), .KEEP_WIDTH(2), .USER_WIDTH(1)) s_if ();
        axis_ready_pipeline_if #(.DATA_WIDTH(16), .KEEP_WIDTH(2), .USER_WIDTH(1)) m_if ();
        logic ovf;

        axis_ready_pipeline #(
            .DATA_WIDTH  (16),
            .KEEP_ENABLE (KE),
            .KEEP_WIDTH  (2),
            .LAST_ENABLE (LE),
            .USER_ENABLE (1'b1),
            .USER_WIDTH  (1),
            .LENGTH      (L),
            .FIFO_DEPTH  (D)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .s_axis          (s_if),
            .m_axis          (m_if),
            .status_overflow (ovf)
        );

        logic [19:0] mq [$];
        fl_t         fl [$];
        bit          hist [$];
        int cyc = 0, first_rdy = -1, deliv = 0, first_deliv = -1, last_deliv = -1;
        int peak = 0, occ = 0, mvh = 0, n = 0;
        bit acc_s = 1'b0, exp_rdy, exp_mv;
        logic [19:0] tb_beat;

        // Source and sink driver.
        initial begin
            s_if.tvalid = 1'b0;
            {s_if.tdata, s_if.tkeep, s_if.tlast, s_if.tuser} = mk(0);
            m_if.tready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                if (acc_s) n++;
                case (src_mode[gi])
                    1: s_if.tvalid = (n < lim[gi]);
                    2: if (!(s_if.tvalid && !acc_s)) s_if.tvalid = 1'($urandom_range(0, 1));
                    default: s_if.tvalid = 1'b0;
                endcase
                {s_if.tdata, s_if.tkeep, s_if.tlast, s_if.tuser} = mk(n);
                case (snk_mode[gi])
                    1: m_if.tready = 1'b1;
                    2: m_if.tready = 1'($urandom_range(0, 1));
                    default: m_if.tready = 1'b0;
                endcase
            end
        end

        // Model and per-cycle compare.
        always @(negedge clk) begin
            if (rst) begin
                mq.delete();
                fl.delete();
                hist.delete();
                for (int i = 0; i <= L; i++) hist.push_back(1'b0);
                cyc = 0; first_rdy = -1; acc_s = 1'b0; mvh = 0; occ = 0;
                if (chk_en[gi]) begin
                    chk("rst_s_tready", gi, 32'(s_if.tready), 32'd0);
                    chk("rst_m_tvalid", gi, 32'(m_if.tvalid), 32'd0);
                end
            end else if (chk_en[gi]) begin
                exp_rdy = hist[0];
                exp_mv  = (mq.size() != 0);
                occ     = mq.size();
                chk("s_tready", gi, 32'(s_if.tready), 32'(exp_rdy));
                chk("m_tvalid", gi, 32'(m_if.tvalid), 32'(exp_mv));
                chk("status_overflow", gi, 32'(ovf), 32'd0);
                if (exp_mv && m_if.tvalid) begin
                    chk("payload", gi, 32'({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}),
                        32'(mq[0]));
                    if (!LE) chk("tlast_forced", gi, 32'(m_if.tlast), 32'd1);
                    if (!KE) chk("tkeep_forced", gi, 32'(m_if.tkeep), 32'd3);
                end
                if (m_if.tvalid) mvh++;
                if (s_if.tready && first_rdy < 0) first_rdy = cyc;
                acc_s = s_if.tvalid && s_if.tready;
                if (exp_mv && m_if.tready) begin
                    void'(mq.pop_front());
                    deliv++;
                    last_deliv = cyc;
                    if (first_deliv < 0) first_deliv = cyc;
                end
                if (s_if.tvalid && exp_rdy) begin
                    tb_beat = {s_if.tdata, KE ? s_if.tkeep : 2'b11, LE ? s_if.tlast : 1'b1,
                               s_if.tuser};
                    fl.push_back('{b: tb_beat, arr: cyc + L + 1});
                end
                if (fl.size() != 0 && fl[0].arr == cyc + 1) begin
                    mq.push_back(fl[0].b);
                    void'(fl.pop_front());
                end
                if (mq.size() > peak) peak = mq.size();
                void'(hist.pop_front());
                hist.push_back(mq.size() <= D - 2 * L - 1);
                cyc++;
            end else begin
                acc_s = s_if.tvalid && s_if.tready;
            end
        end
    end

    initial begin
        src_mode = '{1, 2};
        snk_mode = '{1, 2};
        lim      = '{100, 1 << 30};
        chk_en   = '{1'b1, 1'b1};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 100 beats, sink always ready.
        repeat (125) @(negedge clk);
        #1;
        chk("first_ready_cycle", 0, 32'(g[0].first_rdy), 32'd3);
        chk("first_ready_cycle", 1, 32'(g[1].first_rdy), 32'd4);
        chk("beats_delivered", 0, 32'(g[0].deliv), 32'd100);
        chk("first_delivery_cycle", 0, 32'(g[0].first_deliv), 32'd6);
        chk("last_delivery_cycle", 0, 32'(g[0].last_deliv), 32'd105);

        // Continuous stream, then a 20+ cycle sink stall.
        lim[0] = 1 << 30;
        repeat (20) @(negedge clk);
        #1 g[0].peak = 0;
        snk_mode[0] = 0;
        repeat (25) @(negedge clk);
        #1 chk("stall_peak_occupancy", 0, 32'(g[0].peak), 32'd6);
        snk_mode[0] = 1;
        repeat (40) @(negedge clk);

        // Reset with five beats stored.
        snk_mode[0] = 0;
        for (int i = 0; i < 40 && g[0].occ != 5; i++) begin
            @(negedge clk);
            #1;
        end
        chk("reached_five_stored", 0, 32'(g[0].occ), 32'd5);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_m_tvalid", 0, 32'(g[0].m_if.tvalid), 32'd0);
        chk("async_rst_s_tready", 0, 32'(g[0].s_if.tready), 32'd0);
        src_mode[0] = 0;
        snk_mode[0] = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("no_stale_beats", 0, 32'(g[0].mvh), 32'd0);
        chk("ready_after_reset", 0, 32'(g[0].first_rdy), 32'd3);
        src_mode[0] = 1;
        repeat (40) @(negedge clk);

`ifdef AXIS_READY_PIPE_OVF_CHECK_EN
        // Forced-full FIFO: the next push must raise the sticky flag.
        chk_en[0] = 1'b0;
        snk_mode[0] = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        force g[0].u_dut.u_fifo.count_q = 3'd6;
        repeat (8) @(negedge clk);
        #1 chk("overflow_set", 0, 32'(g[0].ovf), 32'd1);
        repeat (5) @(negedge clk);
        #1 chk("overflow_sticky", 0, 32'(g[0].ovf), 32'd1);
        release g[0].u_dut.u_fifo.count_q;
        rst = 1'b1;
        #1 chk("overflow_cleared", 0, 32'(g[0].ovf), 32'd0);
        chk_en[0] = 1'b1;
        snk_mode[0] = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
`endif

        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
